hazard_control_unit: RTL and testbench

- Produces the stall, flush, freeze and operand-forwarding controls consumed by the decode stage (stall_i, flush_i, forward_reg1_i, forward_reg2_i), plus the PC/IF hold.
- Keeps a shadow of the destination-register state of the EX and MEM stages, so it needs only decode-side information each cycle.
- Sits beside the five-stage RV32I pipeline and closes the loop from EX/MEM back into ID.

---
 rtl/hazard_control_unit.sv | 142 ++++++++++++++
 tb/tb_hazard_control_unit.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_control_unit.sv
// rtl/hazard_control_unit.sv - load-use stall, branch flush, memory freeze and forwarding control
// Tracks EX/MEM destination shadows so only decode-side inputs are needed each cycle.
module hazard_control_unit #(
    parameter int         CNT_W   = 16,
    parameter logic [1:0] FWD_RF  = 2'b00,
    parameter logic [1:0] FWD_EX  = 2'b01,
    parameter logic [1:0] FWD_MEM = 2'b10
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             id_valid_i,
    input  logic [4:0]       id_rs1_addr_i,
    input  logic [4:0]       id_rs2_addr_i,
    input  logic             id_uses_rs1_i,
    input  logic             id_uses_rs2_i,
    input  logic [4:0]       id_rd_addr_i,
    input  logic             id_rd_wr_en_i,
    input  logic             id_is_load_i,
    input  logic             branch_taken_i,
    input  logic             mem_busy_i,
    output logic             stall_o,
    output logic             pc_hold_o,
    output logic             flush_o,
    output logic             freeze_o,
    output logic [1:0]       forward_reg1_o,
    output logic [1:0]       forward_reg2_o,
    output logic [CNT_W-1:0] stall_count_o,
    output logic [CNT_W-1:0] flush_count_o
);

    typedef enum logic [1:0] {
        ST_RUN,
        ST_STALL_LU,
        ST_FREEZE
    } state_e;

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_e           state_q, state_d;
    logic             ex_valid_q, ex_wr_q, ex_ld_q;
    logic [4:0]       ex_rd_q;
    logic             mem_valid_q, mem_wr_q;
    logic [4:0]       mem_rd_q;
    logic             pending_flush_q;
    logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;

    logic ex_match1, ex_match2, mem_match1, mem_match2;
    logic load_use, freeze_w, flush_w, stall_w;

    assign ex_match1  = ex_valid_q & ex_wr_q & (ex_rd_q == id_rs1_addr_i)
                      & (id_rs1_addr_i != 5'd0) & id_uses_rs1_i;
    assign ex_match2  = ex_valid_q & ex_wr_q & (ex_rd_q == id_rs2_addr_i)
                      & (id_rs2_addr_i != 5'd0) & id_uses_rs2_i;
    assign mem_match1 = mem_valid_q & mem_wr_q & (mem_rd_q == id_rs1_addr_i)
                      & (id_rs1_addr_i != 5'd0) & id_uses_rs1_i;
    assign mem_match2 = mem_valid_q & mem_wr_q & (mem_rd_q == id_rs2_addr_i)
                      & (id_rs2_addr_i != 5'd0) & id_uses_rs2_i;

    assign load_use = id_valid_i & ex_ld_q & (ex_match1 | ex_match2);

    // A deferred flush can only be pending on the cycle right after a freeze,
    // which is always spent in ST_FREEZE with mem_busy_i already low.
    assign freeze_w = mem_busy_i;
    assign flush_w  = ~freeze_w & (branch_taken_i | (pending_flush_q & (state_q == ST_FREEZE)));
    assign stall_w  = ~freeze_w & ~flush_w & load_use;

    always_comb begin
        state_d = ST_RUN;
        if (freeze_w) begin
            state_d = ST_FREEZE;
        end else if (stall_w) begin
            state_d = ST_STALL_LU;
        end
    end

    // Outputs read as zero the instant reset asserts, without waiting for a clock.
    assign stall_o   = rst_ni & stall_w;
    assign pc_hold_o = rst_ni & (stall_w | freeze_w);
    assign flush_o   = rst_ni & flush_w;
    assign freeze_o  = rst_ni & freeze_w;

    always_comb begin
        forward_reg1_o = FWD_RF;
        if (ex_match1 && !ex_ld_q) begin
            forward_reg1_o = FWD_EX;
        end else if (mem_match1) begin
            forward_reg1_o = FWD_MEM;
        end
    end

    always_comb begin
        forward_reg2_o = FWD_RF;
        if (ex_match2 && !ex_ld_q) begin
            forward_reg2_o = FWD_EX;
        end else if (mem_match2) begin
            forward_reg2_o = FWD_MEM;
        end
    end

    assign stall_count_o = stall_cnt_q;
    assign flush_count_o = flush_cnt_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q         <= ST_RUN;
            ex_valid_q      <= 1'b0;
            ex_wr_q         <= 1'b0;
            ex_ld_q         <= 1'b0;
            ex_rd_q         <= 5'd0;
            mem_valid_q     <= 1'b0;
            mem_wr_q        <= 1'b0;
            mem_rd_q        <= 5'd0;
            pending_flush_q <= 1'b0;
            stall_cnt_q     <= '0;
            flush_cnt_q     <= '0;
        end else begin
            state_q <= state_d;
            if (freeze_w && branch_taken_i) begin
                pending_flush_q <= 1'b1;
            end else if (flush_w) begin
                pending_flush_q <= 1'b0;
            end
            if (!freeze_w) begin
                mem_valid_q <= ex_valid_q;
                mem_wr_q    <= ex_wr_q;
                mem_rd_q    <= ex_rd_q;
                ex_valid_q  <= id_valid_i & ~(stall_w | flush_w);
                ex_wr_q     <= id_rd_wr_en_i;
                ex_ld_q     <= id_is_load_i & id_valid_i & ~(stall_w | flush_w);
                ex_rd_q     <= id_rd_addr_i;
            end
            if (stall_w && stall_cnt_q != CNT_MAX) begin
                stall_cnt_q <= stall_cnt_q + CNT_ONE;
            end
            if (flush_w && flush_cnt_q != CNT_MAX) begin
                flush_cnt_q <= flush_cnt_q + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_hazard_control_unit.sv
// tb/tb_hazard_control_unit.sv - vector table and scoreboard bench for hazard_control_unit
module tb_hazard_control_unit;

    typedef struct {
        logic       v;
        logic [4:0] rs1;
        logic [4:0] rs2;
        logic       u1;
        logic       u2;
        logic [4:0] rd;
        logic       wr;
        logic       ld;
        logic       br;
        logic       busy;
        logic       e_stall;
        logic       e_hold;
        logic       e_flush;
        logic       e_freeze;
        logic [1:0] e_f1;
        logic [1:0] e_f2;
        int         e_scnt;
        int         e_fcnt;
    } vec_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        id_valid, id_uses_rs1, id_uses_rs2, id_rd_wr_en, id_is_load;
    logic [4:0]  id_rs1, id_rs2, id_rd;
    logic        branch_taken, mem_busy;
    logic        stall, pc_hold, flush, freeze;
    logic [1:0]  fwd1, fwd2;
    logic [15:0] scnt, fcnt;
    logic        stall4, pc_hold4, flush4, freeze4;
    logic [1:0]  fwd1_4, fwd2_4;
    logic [3:0]  scnt4, fcnt4;

    int   n_pass = 0;
    int   n_total = 0;
    vec_t tbl[17];
    vec_t exp_q[$];

    always #5 clk = ~clk;

    hazard_control_unit #(.CNT_W(16)) dut (
        .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid),
        .id_rs1_addr_i(id_rs1), .id_rs2_addr_i(id_rs2),
        .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
        .id_rd_addr_i(id_rd), .id_rd_wr_en_i(id_rd_wr_en), .id_is_load_i(id_is_load),
        .branch_taken_i(branch_taken), .mem_busy_i(mem_busy),
        .stall_o(stall), .pc_hold_o(pc_hold), .flush_o(flush), .freeze_o(freeze),
        .forward_reg1_o(fwd1), .forward_reg2_o(fwd2),
        .stall_count_o(scnt), .flush_count_o(fcnt)
    );

    hazard_control_unit #(.CNT_W(4)) dut4 (
        .clk_i(clk), .rst_ni(rst_n), .id_valid_i(id_valid),
        .id_rs1_addr_i(id_rs1), .id_rs2_addr_i(id_rs2),
        .id_uses_rs1_i(id_uses_rs1), .id_uses_rs2_i(id_uses_rs2),
        .id_rd_addr_i(id_rd), .id_rd_wr_en_i(id_rd_wr_en), .id_is_load_i(id_is_load),
        .branch_taken_i(branch_taken), .mem_busy_i(mem_busy),
        .stall_o(stall4), .pc_hold_o(pc_hold4), .flush_o(flush4), .freeze_o(freeze4),
        .forward_reg1_o(fwd1_4), .forward_reg2_o(fwd2_4),
        .stall_count_o(scnt4), .flush_count_o(fcnt4)
    );

    function automatic vec_t mk(input logic v, input int rs1, input int rs2,
                                input logic u1, input logic u2, input int rd,
                                input logic wr, input logic ld, input logic br, input logic busy,
                                input logic st, input logic hd, input logic fl, input logic fz,
                                input logic [1:0] f1, input logic [1:0] f2,
                                input int sc, input int fc);
        vec_t r;
        r.v = v; r.rs1 = 5'(rs1); r.rs2 = 5'(rs2); r.u1 = u1; r.u2 = u2;
        r.rd = 5'(rd); r.wr = wr; r.ld = ld; r.br = br; r.busy = busy;
        r.e_stall = st; r.e_hold = hd; r.e_flush = fl; r.e_freeze = fz;
        r.e_f1 = f1; r.e_f2 = f2; r.e_scnt = sc; r.e_fcnt = fc;
        return r;
    endfunction

    task automatic chk(input string name, input int act, input int req);
        n_total++;
        if (act == req) n_pass++;
        else $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    endtask

    task automatic drive(input vec_t x);
        id_valid = x.v; id_rs1 = x.rs1; id_rs2 = x.rs2;
        id_uses_rs1 = x.u1; id_uses_rs2 = x.u2; id_rd = x.rd;
        id_rd_wr_en = x.wr; id_is_load = x.ld; branch_taken = x.br; mem_busy = x.busy;
    endtask

    task automatic check_front(input string tag);
        vec_t e;
        if (exp_q.size() == 0) begin
            chk({tag, " scoreboard_empty"}, 1, 0);
            return;
        end
        e = exp_q.pop_front();
        chk({tag, " stall"}, int'(stall), int'(e.e_stall));
        chk({tag, " pc_hold"}, int'(pc_hold), int'(e.e_hold));
        chk({tag, " flush"}, int'(flush), int'(e.e_flush));
        chk({tag, " freeze"}, int'(freeze), int'(e.e_freeze));
        chk({tag, " fwd1"}, int'(fwd1), int'(e.e_f1));
        chk({tag, " fwd2"}, int'(fwd2), int'(e.e_f2));
        chk({tag, " stall_cnt"}, int'(scnt), e.e_scnt);
        chk({tag, " flush_cnt"}, int'(fcnt), e.e_fcnt);
        chk({tag, " stall_cnt4"}, int'(scnt4), (e.e_scnt > 15) ? 15 : e.e_scnt);
        chk({tag, " flush_cnt4"}, int'(fcnt4), (e.e_fcnt > 15) ? 15 : e.e_fcnt);
    endtask

    task automatic run_cycle(input vec_t x, input string tag);
        drive(x);
        exp_q.push_back(x);
        #3;
        check_front(tag);
        @(posedge clk);
        #1;
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, " stall"}, int'(stall | stall4), 0);
        chk({tag, " pc_hold"}, int'(pc_hold | pc_hold4), 0);
        chk({tag, " flush"}, int'(flush | flush4), 0);
        chk({tag, " freeze"}, int'(freeze | freeze4), 0);
        chk({tag, " fwd"}, int'({fwd1, fwd2, fwd1_4, fwd2_4}), 0);
        chk({tag, " counts"}, int'(scnt) + int'(fcnt) + int'(scnt4) + int'(fcnt4), 0);
    endtask

    initial begin
        int sc;
        vec_t idle;
        idle = mk(0,0,0,0,0,0,0,0,0,0, 0,0,0,0,2'b00,2'b00,0,0);
        rst_n = 1'b0;
        drive(idle);

        //           v rs1 rs2 u1 u2 rd wr ld br bz | st hd fl fz f1     f2    sc fc
        tbl[0]  = mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        tbl[1]  = mk(1, 1,  2, 1, 1, 5, 1, 0, 0, 0,   0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        tbl[2]  = mk(1, 5,  1, 1, 1, 6, 1, 0, 0, 0,   0, 0, 0, 0, 2'b01, 2'b00, 0, 0);
        tbl[3]  = mk(1, 3,  5, 1, 1,10, 1, 0, 0, 0,   0, 0, 0, 0, 2'b00, 2'b10, 0, 0);
        tbl[4]  = mk(1, 3,  4, 1, 1, 0, 1, 0, 0, 0,   0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        tbl[5]  = mk(1, 0,  0, 1, 1,11, 1, 0, 0, 0,   0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        tbl[6]  = mk(1,12,  0, 1, 0, 7, 1, 1, 0, 0,   0, 0, 0, 0, 2'b00, 2'b00, 0, 0);
        tbl[7]  = mk(1, 7,  7, 1, 1, 8, 1, 0, 0, 0,   1, 1, 0, 0, 2'b00, 2'b00, 0, 0);
        tbl[8]  = mk(1, 7,  7, 1, 1, 8, 1, 0, 0, 0,   0, 0, 0, 0, 2'b10, 2'b10, 1, 0);
        tbl[9]  = mk(1, 8,  0, 1, 0,13, 1, 1, 0, 0,   0, 0, 0, 0, 2'b01, 2'b00, 1, 0);
        tbl[10] = mk(1,13,  0, 1, 1,14, 1, 0, 1, 0,   0, 0, 1, 0, 2'b00, 2'b00, 1, 0);
        tbl[11] = mk(1,14,  0, 1, 0,15, 1, 0, 0, 0,   0, 0, 0, 0, 2'b00, 2'b00, 1, 1);
        tbl[12] = mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 0, 1, 2'b00, 2'b00, 1, 1);
        tbl[13] = mk(0, 0,  0, 0, 0, 0, 0, 0, 1, 1,   0, 1, 0, 1, 2'b00, 2'b00, 1, 1);
        tbl[14] = mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 1,   0, 1, 0, 1, 2'b00, 2'b00, 1, 1);
        tbl[15] = mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 1, 0, 2'b00, 2'b00, 1, 1);
        tbl[16] = mk(0, 0,  0, 0, 0, 0, 0, 0, 0, 0,   0, 0, 0, 0, 2'b00, 2'b00, 1, 2);

        repeat (2) @(posedge clk);
        #1;
        chk_all_zero("reset");
        rst_n = 1'b1;

        for (int i = 0; i < 17; i++) begin
            run_cycle(tbl[i], $sformatf("row%0d", i));
        end

        // Twenty lw x7 / add x8,x7,x7 pairs; the 4-bit instance must pin at 15.
        sc = 1;
        for (int i = 0; i < 20; i++) begin
            run_cycle(mk(1,12,0,1,0,7,1,1,0,0, 0,0,0,0,2'b00,2'b00,sc,2), $sformatf("sat%0d_lw", i));
            run_cycle(mk(1,7,7,1,1,8,1,0,0,0, 1,1,0,0,2'b00,2'b00,sc,2), $sformatf("sat%0d_use", i));
            sc++;
            run_cycle(mk(1,7,7,1,1,8,1,0,0,0, 0,0,0,0,2'b10,2'b10,sc,2), $sformatf("sat%0d_fwd", i));
        end
        chk("sat stall_cnt16", int'(scnt), 21);
        chk("sat stall_cnt4", int'(scnt4), 15);

        // Asynchronous reset in the middle of a freeze that has a flush pending.
        drive(mk(0,0,0,0,0,0,0,0,1,1, 0,0,0,0,2'b00,2'b00,0,0));
        #3;
        chk("arst pre freeze", int'(freeze), 1);
        @(posedge clk);
        #1;
        drive(mk(0,0,0,0,0,0,0,0,0,1, 0,0,0,0,2'b00,2'b00,0,0));
        #3;
        chk("arst pre freeze2", int'(freeze), 1);
        rst_n = 1'b0;
        #1;
        chk_all_zero("arst");
        @(posedge clk);
        #1;
        drive(idle);
        rst_n = 1'b1;
        #3;
        chk("arst pending dropped", int'(flush), 0);
        chk("arst freeze released", int'(freeze), 0);
        @(posedge clk);
        #1;
        chk("arst flush_cnt", int'(fcnt), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
